// File: rtl/seg7_mux_driver.sv
// rtl/seg7_mux_driver.sv - two-digit time-multiplexed 7-segment driver with inter-digit blanking
// Optional feature macro: SEG7_LEADING_ZERO_BLANK_EN (blank a zero tens digit)
module seg7_mux_driver #(
   parameter int DIGIT_TIME = 4,
   parameter int BLANK_TIME = 1
) (
   input  logic       clk_1khz,
   input  logic       rst_ni,
   input  logic [3:0] tens_i,
   input  logic [3:0] ones_i,
   output logic [6:0] seg_o,
   output logic [1:0] digit_en_o,
   output logic       frame_o
);

   localparam int MAX_TIME = (DIGIT_TIME > BLANK_TIME) ? DIGIT_TIME : BLANK_TIME;
   localparam int TW       = (MAX_TIME < 2) ? 1 : $clog2(MAX_TIME + 1);

   localparam logic [TW-1:0] DIGIT_LAST = TW'(DIGIT_TIME - 1);
   localparam logic [TW-1:0] BLANK_LAST = TW'((BLANK_TIME > 0) ? (BLANK_TIME - 1) : 0);
   localparam logic          SKIP_BLANK = (BLANK_TIME == 0);

   typedef enum logic [1:0] {
      TENS_ON    = 2'd0,
      TENS_BLANK = 2'd1,
      ONES_ON    = 2'd2,
      ONES_BLANK = 2'd3
   } state_t;

   state_t        state_q;
   state_t        state_d;
   logic [TW-1:0] timer_q;
   logic [TW-1:0] timer_d;
   logic [3:0]    tens_q;
   logic [3:0]    tens_d;
   logic [3:0]    ones_q;
   logic [3:0]    ones_d;
   logic          boot_q;
   logic          enter_tens;
   logic [6:0]    seg_d;
   logic [1:0]    en_d;
   logic          frame_d;

   function automatic logic [6:0] decode(input logic [3:0] code);
      logic [6:0] pattern;
      case (code)
         4'd0:    pattern = 7'h3F;
         4'd1:    pattern = 7'h06;
         4'd2:    pattern = 7'h5B;
         4'd3:    pattern = 7'h4F;
         4'd4:    pattern = 7'h66;
         4'd5:    pattern = 7'h6D;
         4'd6:    pattern = 7'h7D;
         4'd7:    pattern = 7'h07;
         4'd8:    pattern = 7'h7F;
         4'd9:    pattern = 7'h6F;
         4'd10:   pattern = 7'h00;
         4'd11:   pattern = 7'h73;
         default: pattern = 7'h40;
      endcase
      return pattern;
   endfunction

   function automatic logic [6:0] tens_pattern(input logic [3:0] code);
`ifdef SEG7_LEADING_ZERO_BLANK_EN
      return (code == 4'd0) ? 7'h00 : decode(code);
`else
      return decode(code);
`endif
   endfunction

   // boot_q lets the reset-state ONES_BLANK exit after one cycle whatever BLANK_TIME is.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         TENS_ON: begin
            if (timer_q == DIGIT_LAST) state_d = SKIP_BLANK ? ONES_ON : TENS_BLANK;
         end
         TENS_BLANK: begin
            if (timer_q == BLANK_LAST) state_d = ONES_ON;
         end
         ONES_ON: begin
            if (timer_q == DIGIT_LAST) state_d = SKIP_BLANK ? TENS_ON : ONES_BLANK;
         end
         ONES_BLANK: begin
            if (boot_q || SKIP_BLANK || (timer_q == BLANK_LAST)) state_d = TENS_ON;
         end
         default: state_d = ONES_BLANK;
      endcase

      enter_tens = (state_d == TENS_ON) && (state_q != TENS_ON);
      timer_d    = (state_d != state_q) ? '0 : timer_q + TW'(1);
      tens_d     = enter_tens ? tens_i : tens_q;
      ones_d     = enter_tens ? ones_i : ones_q;

      // Outputs are computed from the next state so they change on the same edge.
      seg_d   = 7'h00;
      en_d    = 2'b00;
      frame_d = enter_tens;
      case (state_d)
         TENS_ON: begin
            en_d  = 2'b10;
            seg_d = tens_pattern(tens_d);
         end
         ONES_ON: begin
            en_d  = 2'b01;
            seg_d = decode(ones_d);
         end
         default: begin
            en_d  = 2'b00;
            seg_d = 7'h00;
         end
      endcase
   end

   always_ff @(posedge clk_1khz) begin
      if (!rst_ni) begin
         state_q    <= ONES_BLANK;
         timer_q    <= '0;
         boot_q     <= 1'b1;
         tens_q     <= 4'd10;
         ones_q     <= 4'd10;
         seg_o      <= 7'h00;
         digit_en_o <= 2'b00;
         frame_o    <= 1'b0;
      end else begin
         state_q    <= state_d;
         timer_q    <= timer_d;
         boot_q     <= 1'b0;
         tens_q     <= tens_d;
         ones_q     <= ones_d;
         seg_o      <= seg_d;
         digit_en_o <= en_d;
         frame_o    <= frame_d;
      end
   end

endmodule

// File: tb/tb_seg7_mux_driver.sv
// tb/tb_seg7_mux_driver.sv - directed-vector bench for seg7_mux_driver
// Honours SEG7_LEADING_ZERO_BLANK_EN when computing the zero-tens expectation.
module tb_seg7_mux_driver;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [3:0] tens;
   logic [3:0] ones;
   logic [6:0] seg_a;
   logic [1:0] en_a;
   logic       fr_a;
   logic [6:0] seg_b;
   logic [1:0] en_b;
   logic       fr_b;

   int n_cmp = 0;
   int n_bad = 0;

`ifdef SEG7_LEADING_ZERO_BLANK_EN
   localparam logic [6:0] TENS_ZERO = 7'h00;
`else
   localparam logic [6:0] TENS_ZERO = 7'h3F;
`endif

   always #5 clk = ~clk;

   seg7_mux_driver #(.DIGIT_TIME(4), .BLANK_TIME(1)) dut_a (
      .clk_1khz   (clk),
      .rst_ni     (rst_n),
      .tens_i     (tens),
      .ones_i     (ones),
      .seg_o      (seg_a),
      .digit_en_o (en_a),
      .frame_o    (fr_a)
   );

   seg7_mux_driver #(.DIGIT_TIME(1), .BLANK_TIME(0)) dut_b (
      .clk_1khz   (clk),
      .rst_ni     (rst_n),
      .tens_i     (tens),
      .ones_i     (ones),
      .seg_o      (seg_b),
      .digit_en_o (en_b),
      .frame_o    (fr_b)
   );

   task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Checks one 10-cycle frame of dut_a starting at its first cycle; optionally
   // changes the inputs right after cycle chg_at has been checked.
   task automatic check_frame(input string name, input logic [6:0] tseg, input logic [6:0] oseg,
                              input int chg_at, input logic [3:0] t_new, input logic [3:0] o_new);
      logic [1:0] e_en;
      logic [6:0] e_seg;
      for (int k = 0; k < 10; k++) begin
         if (k < 4) begin
            e_en = 2'b10; e_seg = tseg;
         end else if (k >= 5 && k < 9) begin
            e_en = 2'b01; e_seg = oseg;
         end else begin
            e_en = 2'b00; e_seg = 7'h00;
         end
         chk($sformatf("%s k%0d en", name, k), {6'd0, en_a}, {6'd0, e_en});
         chk($sformatf("%s k%0d seg", name, k), {1'b0, seg_a}, {1'b0, e_seg});
         chk($sformatf("%s k%0d frame", name, k), {7'd0, fr_a}, {7'd0, (k == 0)});
         if (k == chg_at) begin
            tens = t_new;
            ones = o_new;
         end
         tick();
      end
   endtask

   initial begin
      rst_n = 1'b0;
      tens  = 4'd4;
      ones  = 4'd2;
      tick();
      tick();
      chk("reset seg", {1'b0, seg_a}, 8'h00);
      chk("reset en", {6'd0, en_a}, 8'h00);
      chk("reset frame", {7'd0, fr_a}, 8'h00);

      rst_n = 1'b1;
      tick();
      check_frame("f0 4/2", 7'h66, 7'h5B, -1, 4'd0, 4'd0);
      check_frame("f1 4/2", 7'h66, 7'h5B, 6, 4'd7, 4'd2);
      check_frame("f2 7/2", 7'h07, 7'h5B, 9, 4'd11, 4'd1);
      check_frame("f3 11/1", 7'h73, 7'h06, 2, 4'd10, 4'd10);
      check_frame("f4 10/10", 7'h00, 7'h00, 9, 4'd13, 4'd9);
      check_frame("f5 13/9", 7'h40, 7'h6F, 7, 4'd0, 4'd5);
      check_frame("f6 0/5", TENS_ZERO, 7'h6D, -1, 4'd0, 4'd0);

      rst_n = 1'b0;
      tick();
      chk("midreset seg", {1'b0, seg_a}, 8'h00);
      chk("midreset en", {6'd0, en_a}, 8'h00);
      chk("midreset frame", {7'd0, fr_a}, 8'h00);
      chk("midreset b en", {6'd0, en_b}, 8'h00);
      rst_n = 1'b1;
      tick();
      check_frame("after reset", TENS_ZERO, 7'h6D, -1, 4'd0, 4'd0);

      for (int k = 0; k < 6; k++) begin
         chk($sformatf("nob k%0d en", k), {6'd0, en_b}, (k % 2 == 0) ? 8'h02 : 8'h01);
         chk($sformatf("nob k%0d seg", k), {1'b0, seg_b}, (k % 2 == 0) ? {1'b0, TENS_ZERO} : 8'h6D);
         chk($sformatf("nob k%0d frame", k), {7'd0, fr_b}, (k % 2 == 0) ? 8'h01 : 8'h00);
         tick();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
